// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue sequencer between IDU1 and the single-cycle ALU
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   idu_valid/ready   packet handshake from IDU1 (idu_ctrl carries the packet)
//   alu_ctrl          packet issued to the ALU (idle packet when nothing issues)
//   alu_pc_load       registered pc_load from the ALU, meaningful in BR_WAIT only
//   ifu_flush         redirect flush to the front end
//   occupancy         current FIFO entry count
//   issue_cnt         saturating count of issued packets
//   flush_cnt         saturating count of taken redirects

package alu_issue_pkg;

    typedef struct packed {
        logic        legal;
        logic        nop;
        logic        alu;
        logic        jal;
        logic        condbr;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } idu1_out_t;

    // Idle packet: every field zero except nop.
    function automatic idu1_out_t idle_pkt();
        idu1_out_t p;
        p     = '0;
        p.nop = 1'b1;
        return p;
    endfunction

endpackage

module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       idu_valid,
    output logic                       idu_ready,
    input  idu1_out_t                  idu_ctrl,
    output idu1_out_t                  alu_ctrl,
    input  logic                       alu_pc_load,
    output logic                       ifu_flush,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           issue_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {
        RUN,
        BR_WAIT
    } state_t;

    idu1_out_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;
    state_t             state;

    idu1_out_t          head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               head_cf;

    assign head  = mem[rd_ptr];
    assign full  = (count == OCC_W'(DEPTH));
    assign empty = (count == '0);

    // Control flow holds issue until the ALU resolves it one cycle later.
    assign head_cf = (head.jal | head.condbr) & head.alu & head.legal & ~head.nop;

    // Reset gating keeps outputs quiet on the first reset cycle, before the
    // registered state has been cleared.
    assign pop       = ~rst & (state == RUN) & ~empty;
    assign ifu_flush = ~rst & (state == BR_WAIT) & alu_pc_load;
    assign idu_ready = ~full & ~rst & ~ifu_flush;
    assign push      = idu_valid & idu_ready;

    assign alu_ctrl  = pop ? head : idle_pkt();
    assign occupancy = rst ? '0 : count;

    // Storage carries no reset; only count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= idu_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            issue_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (ifu_flush) begin
                // Push is blocked this cycle, so wr_ptr is stable here.
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + OCC_W'(1);
                    2'b01:   count <= count - OCC_W'(1);
                    default: count <= count;
                endcase
            end

            case (state)
                RUN:     state <= (pop && head_cf) ? BR_WAIT : RUN;
                BR_WAIT: state <= RUN;
                default: state <= RUN;
            endcase

            if (pop && (issue_cnt != '1)) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (ifu_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
